ladybird_bus_arbiter: RTL and testbench
=======================================

# ladybird_bus_arbiter

Round-robin arbiter that lets `N_PRI` bus primaries (fetch unit, load/store unit, debug/loader port) share one `ladybird_bus` secondary such as the on-chip RAM. It forwards exactly one request per cycle and tracks the single outstanding read. It steers the returning read data and `data_gnt` only to the primary that issued the read. A timeout counter keeps a missing responder from hanging the system.

## Interface
- `N_PRI`, default 3: number of primaries, 2..8
- `ADDR_W`, default 32: bus address width
- `DATA_W`, default 32: bus data width
- `TIMEOUT`, default 255: cycles to wait for `data_gnt` before aborting a read, 1..65535
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on timeout

Ports:
- `clk`  in  1  clock
- `arst`  in  1  reset, asynchronous, active-high
- `pri_req`  in  N_PRI  per-primary request
- `pri_addr`  in  N_PRI×ADDR_W  per-primary address
- `pri_wstrb`  in  N_PRI×4  per-primary byte strobes; nonzero means write, zero means read
- `pri_wdata`  in  N_PRI×DATA_W  per-primary write data
- `pri_gnt`  out  N_PRI  one-hot request accepted
- `pri_data_gnt`  out  N_PRI  one-hot read data valid
- `pri_rdata`  out  DATA_W  read data, shared by all primaries, qualified by `pri_data_gnt`
- `pri_err`  out  N_PRI  one-hot, pulses together with `pri_data_gnt` on timeout
- `sec_req`, `sec_addr`, `sec_wstrb`, `sec_wdata`  out  1/ADDR_W/4/DATA_W  forwarded request
- `sec_gnt`  in  1  secondary accepted request
- `sec_data_gnt`  in  1  secondary read data valid
- `sec_rdata`  in  DATA_W  secondary read data

## Operation
- FSM has two states, `IDLE` and `RD_WAIT`.
- Reset (`arst`=1) sets the state to `IDLE`, `rr_ptr` to 0, `owner` to 0 and `tmo_cnt` to 0. All outputs read 0 while reset is asserted.
- **IDLE**
  - Winner is the first requester searched from `rr_ptr` upward, wrapping modulo `N_PRI`.
  - The winner's addr/wstrb/wdata are driven on `sec_*` combinationally, with `sec_req`=1.
  - `pri_gnt[winner]` = `sec_gnt`.
  - On `sec_gnt`, `rr_ptr` is set to winner+1 modulo `N_PRI`.
  - An accepted write stays in `IDLE` and needs no response.
  - An accepted read latches `owner`=winner, clears `tmo_cnt` and moves to `RD_WAIT`.
  - No `sec_gnt`: the grant is not given and `rr_ptr` is unchanged. The same winner is re-evaluated next cycle, but a higher-priority request arriving meanwhile may overtake it.
- **RD_WAIT**
  - `sec_req`=0 and all `pri_gnt`=0; other requesters wait.
  - `sec_data_gnt`=1: `pri_data_gnt[owner]`=1 and `pri_rdata`=`sec_rdata` in the same cycle, then back to `IDLE`.
  - Otherwise `tmo_cnt` increments. When `tmo_cnt`==`TIMEOUT`-1 and there is still no data: `pri_data_gnt[owner]`=1, `pri_err[owner]`=1, `pri_rdata`=`ERR_DATA`, then back to `IDLE`.
  - A late `sec_data_gnt` arriving in `IDLE` is ignored.
- Primaries hold req/addr/wstrb/wdata stable until they see `pri_gnt`. A primary dropping `req` before its grant is legal and simply removes it from arbitration.
- `pri_rdata` is 0 whenever no `pri_data_gnt` bit is set.

## Timing
- Grant is combinational: a request in cycle t is granted in cycle t when the secondary is free and `sec_gnt`=1. Worst-case wait is `N_PRI`-1 other grants.
- Read against a RAM that returns data one cycle after accept:
  - t0: `pri_gnt`
  - t1: `pri_data_gnt`
  - t2: next arbitration
  - Sustained rate is one read per 2 cycles.
- Back-to-back writes sustain one per cycle, rotating between requesters.
- Timeout fires `TIMEOUT` cycles after the accept cycle.
- `arst` asserted in `RD_WAIT` aborts the read with no `pri_data_gnt` pulse. After release the arbiter restarts in `IDLE` with `rr_ptr`=0.

## Structure
- `ladybird_config` gets a typedef `arb_state_e` {`IDLE`, `RD_WAIT`} and a function `rr_pick(req, ptr)` returning the winner index and a found bit.
- One sub-module, `ladybird_rr_picker`, is natural: purely combinational, rotate, priority-encode, rotate back. It is reusable by future arbiters.
- A wrapper that adapts this block to `ladybird_bus` interface arrays is out of scope.

## Test plan
- **Reset:** `arst` pulse with all reqs high → all outputs 0 during reset. On release, primary 0 is granted first.
- **Round-robin writes:** `pri_req`=3'b111 writes held, `sec_gnt`=1 → grants go 0,1,2,0 on consecutive cycles, each forwarding that primary's addr/wdata.
- **Read routing:** primary 1 reads 0x40 and the RAM returns 0x1234_5678 next cycle → t0 `pri_gnt`=3'b010, t1 `pri_data_gnt`=3'b010 with `pri_rdata`=0x1234_5678. Primary 2's request held throughout is granted at t2.
- **Stalled secondary:** `sec_gnt`=0 for 3 cycles with primary 2 requesting → no grant and `rr_ptr` unchanged; granted on the cycle `sec_gnt` rises.
- **Timeout:** `TIMEOUT`=4 and the read is never answered → on the 4th cycle after accept, `pri_data_gnt[owner]`, `pri_err[owner]` and `pri_rdata`=0xDEAD_BEEF. A late `sec_data_gnt` afterwards produces no output.
- **Reset mid-read:** `arst` asserted in `RD_WAIT` → no `pri_data_gnt`; the state is `IDLE` after release.

Source files
------------

// File: rtl/ladybird_config.sv
// ladybird_config: shared arbiter types and the round-robin search helper
package ladybird_config;
  localparam int MAX_PRI = 8;
  typedef enum logic {IDLE, RD_WAIT} arb_state_e;
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;
  // Descending scan so the requester closest to ptr is written last and wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_PRI-1:0] req, input logic [2:0] ptr, input int n);
    rr_pick_t r;
    int j;
    r = '0;
    for (int i = MAX_PRI - 1; i >= 0; i--) begin
      if (i < n) begin
        j = (int'(ptr) + i) % n;
        if (req[j]) r = '{found: 1'b1, idx: 3'(j)};
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/ladybird_rr_picker.sv
// ladybird_rr_picker: combinational round-robin winner search
//   req   in  N   requests
//   ptr   in  PW  highest-priority index
//   found out 1   any request present
//   idx   out PW  winner index
module ladybird_rr_picker
  import ladybird_config::*;
#(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);
  rr_pick_t pick;
  always_comb pick = rr_pick(MAX_PRI'(req), 3'(ptr), N);
  assign found = pick.found;
  assign idx   = PW'(pick.idx);
endmodule

// File: rtl/ladybird_bus_arbiter.sv
// ladybird_bus_arbiter: round-robin N_PRI-to-1 bus arbiter with read routing and timeout
//   clk, arst                    clock, async active-high reset
//   pri_req/addr/wstrb/wdata     per-primary request (wstrb==0 means read)
//   pri_gnt                      one-hot request accepted
//   pri_data_gnt, pri_err        one-hot read completion / timeout flag
//   pri_rdata                    shared read data, 0 unless pri_data_gnt set
//   sec_req/addr/wstrb/wdata     forwarded request
//   sec_gnt, sec_data_gnt        secondary accept / read data valid
//   sec_rdata                    secondary read data
module ladybird_bus_arbiter
  import ladybird_config::*;
#(
  parameter int               N_PRI    = 3,
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter int               TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [N_PRI-1:0]              pri_req,
  input  logic [N_PRI-1:0][ADDR_W-1:0]  pri_addr,
  input  logic [N_PRI-1:0][3:0]         pri_wstrb,
  input  logic [N_PRI-1:0][DATA_W-1:0]  pri_wdata,
  output logic [N_PRI-1:0]              pri_gnt,
  output logic [N_PRI-1:0]              pri_data_gnt,
  output logic [DATA_W-1:0]             pri_rdata,
  output logic [N_PRI-1:0]              pri_err,
  output logic                          sec_req,
  output logic [ADDR_W-1:0]             sec_addr,
  output logic [3:0]                    sec_wstrb,
  output logic [DATA_W-1:0]             sec_wdata,
  input  logic                          sec_gnt,
  input  logic                          sec_data_gnt,
  input  logic [DATA_W-1:0]             sec_rdata
);
  localparam int PW = $clog2(N_PRI);
  arb_state_e    state;
  logic [PW-1:0] rr_ptr, owner, win;
  logic [15:0]   tmo_cnt;
  logic          found, idle, rd_wait, fwd, tmo_hit, tmo, data_ok, done;
  ladybird_rr_picker #(.N(N_PRI), .PW(PW)) u_picker (
    .req  (pri_req),
    .ptr  (rr_ptr),
    .found(found),
    .idx  (win)
  );
  // Outputs are gated with arst so they read 0 for the whole reset pulse.
  assign idle    = (state == IDLE) && !arst;
  assign rd_wait = (state == RD_WAIT) && !arst;
  assign fwd     = idle && found;
  assign tmo_hit = tmo_cnt == 16'(TIMEOUT - 1);
  assign data_ok = rd_wait && sec_data_gnt;
  assign tmo     = rd_wait && !sec_data_gnt && tmo_hit;
  assign done    = data_ok || tmo;
  assign sec_req      = fwd;
  assign sec_addr     = fwd ? pri_addr[win]  : '0;
  assign sec_wstrb    = fwd ? pri_wstrb[win] : '0;
  assign sec_wdata    = fwd ? pri_wdata[win] : '0;
  assign pri_gnt      = (fwd && sec_gnt) ? N_PRI'(1) << win : '0;
  assign pri_data_gnt = done ? N_PRI'(1) << owner : '0;
  assign pri_err      = tmo  ? N_PRI'(1) << owner : '0;
  assign pri_rdata    = data_ok ? sec_rdata : tmo ? ERR_DATA : '0;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      if (fwd && sec_gnt) begin
        rr_ptr <= (win == PW'(N_PRI - 1)) ? '0 : win + 1'b1;
        if (pri_wstrb[win] == 4'b0) begin
          owner   <= win;
          tmo_cnt <= '0;
          state   <= RD_WAIT;
        end
      end
    end else begin
      if (sec_data_gnt || tmo_hit) state <= IDLE;
      else tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// tb_ladybird_bus_arbiter: directed self-checking bench for ladybird_bus_arbiter
module tb_ladybird_bus_arbiter;
  localparam int N = 3;
  logic               clk = 0;
  logic               arst;
  logic [N-1:0]       pri_req;
  logic [N-1:0][31:0] pri_addr;
  logic [N-1:0][3:0]  pri_wstrb;
  logic [N-1:0][31:0] pri_wdata;
  logic [N-1:0]       pri_gnt, pri_data_gnt, pri_err;
  logic [31:0]        pri_rdata;
  logic               sec_req;
  logic [31:0]        sec_addr, sec_wdata;
  logic [3:0]         sec_wstrb;
  logic               sec_gnt, sec_data_gnt;
  logic [31:0]        sec_rdata;
  int tests = 0;
  int fails = 0;
  ladybird_bus_arbiter #(.N_PRI(N), .TIMEOUT(4)) dut (
    .clk(clk), .arst(arst),
    .pri_req(pri_req), .pri_addr(pri_addr), .pri_wstrb(pri_wstrb), .pri_wdata(pri_wdata),
    .pri_gnt(pri_gnt), .pri_data_gnt(pri_data_gnt), .pri_rdata(pri_rdata), .pri_err(pri_err),
    .sec_req(sec_req), .sec_addr(sec_addr), .sec_wstrb(sec_wstrb), .sec_wdata(sec_wdata),
    .sec_gnt(sec_gnt), .sec_data_gnt(sec_data_gnt), .sec_rdata(sec_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic sample;
    @(negedge clk);
  endtask
  task automatic next;
    @(posedge clk);
    #1;
  endtask
  initial begin
    arst = 1;
    pri_req = 3'b111;
    for (int i = 0; i < N; i++) begin
      pri_addr[i]  = 32'h1000 + 32'(i) * 32'h10;
      pri_wdata[i] = 32'hA0 + 32'(i);
      pri_wstrb[i] = 4'hF;
    end
    sec_gnt = 1; sec_data_gnt = 0; sec_rdata = 32'h0;
    sample;
    chk("rst_gnt", 64'(pri_gnt), 64'h0);
    chk("rst_sec_req", 64'(sec_req), 64'h0);
    chk("rst_sec_addr", 64'(sec_addr), 64'h0);
    chk("rst_data_gnt", 64'(pri_data_gnt), 64'h0);
    chk("rst_rdata", 64'(pri_rdata), 64'h0);
    next;
    arst = 0;
    sample; chk("rr_g0", 64'(pri_gnt), 64'b001); chk("rr_a0", 64'(sec_addr), 64'h1000); chk("rr_d0", 64'(sec_wdata), 64'hA0);
    next;
    sample; chk("rr_g1", 64'(pri_gnt), 64'b010); chk("rr_a1", 64'(sec_addr), 64'h1010); chk("rr_d1", 64'(sec_wdata), 64'hA1);
    next;
    sample; chk("rr_g2", 64'(pri_gnt), 64'b100); chk("rr_a2", 64'(sec_addr), 64'h1020); chk("rr_d2", 64'(sec_wdata), 64'hA2);
    next;
    sample; chk("rr_g3", 64'(pri_gnt), 64'b001); chk("rr_a3", 64'(sec_addr), 64'h1000);
    next;
    pri_req = 3'b110; pri_addr[1] = 32'h40; pri_wstrb[1] = 4'h0;
    sample; chk("rd_t0_gnt", 64'(pri_gnt), 64'b010); chk("rd_t0_addr", 64'(sec_addr), 64'h40); chk("rd_t0_wstrb", 64'(sec_wstrb), 64'h0);
    next;
    pri_req = 3'b100; sec_data_gnt = 1; sec_rdata = 32'h1234_5678;
    sample; chk("rd_t1_gnt", 64'(pri_gnt), 64'b000); chk("rd_t1_sreq", 64'(sec_req), 64'h0);
    chk("rd_t1_dgnt", 64'(pri_data_gnt), 64'b010); chk("rd_t1_data", 64'(pri_rdata), 64'h1234_5678);
    chk("rd_t1_err", 64'(pri_err), 64'h0);
    next;
    sec_data_gnt = 0;
    sample; chk("rd_t2_gnt", 64'(pri_gnt), 64'b100); chk("rd_t2_addr", 64'(sec_addr), 64'h1020); chk("rd_t2_rdata", 64'(pri_rdata), 64'h0);
    next;
    pri_req = 3'b001;
    sample; chk("pre_stall_gnt", 64'(pri_gnt), 64'b001);
    next;
    pri_req = 3'b101; sec_gnt = 0;
    for (int c = 0; c < 3; c++) begin
      sample; chk("stall_gnt", 64'(pri_gnt), 64'b000); chk("stall_addr", 64'(sec_addr), 64'h1020); chk("stall_sreq", 64'(sec_req), 64'h1);
      next;
    end
    sec_gnt = 1;
    sample; chk("stall_rise_gnt", 64'(pri_gnt), 64'b100);
    next;
    pri_req = 3'b001; pri_wstrb[0] = 4'h0;
    sample; chk("tmo_t0_gnt", 64'(pri_gnt), 64'b001);
    next;
    pri_req = 3'b000;
    for (int c = 1; c <= 3; c++) begin
      sample; chk("tmo_wait_dgnt", 64'(pri_data_gnt), 64'h0); chk("tmo_wait_err", 64'(pri_err), 64'h0);
      next;
    end
    sample; chk("tmo_dgnt", 64'(pri_data_gnt), 64'b001); chk("tmo_err", 64'(pri_err), 64'b001); chk("tmo_data", 64'(pri_rdata), 64'hDEAD_BEEF);
    next;
    sec_data_gnt = 1; sec_rdata = 32'h5555_5555;
    sample; chk("late_dgnt", 64'(pri_data_gnt), 64'h0); chk("late_err", 64'(pri_err), 64'h0); chk("late_rdata", 64'(pri_rdata), 64'h0);
    next;
    sec_data_gnt = 0; pri_req = 3'b010;
    sample; chk("mr_t0_gnt", 64'(pri_gnt), 64'b010);
    next;
    pri_req = 3'b000; arst = 1;
    sample; chk("mr_dgnt", 64'(pri_data_gnt), 64'h0);
    sec_data_gnt = 1; sec_rdata = 32'h7777_7777;
    #2; chk("mr_dgnt_sdg", 64'(pri_data_gnt), 64'h0); chk("mr_rdata", 64'(pri_rdata), 64'h0);
    next;
    arst = 0;
    sample; chk("mr_idle_dgnt", 64'(pri_data_gnt), 64'h0); chk("mr_idle_rdata", 64'(pri_rdata), 64'h0);
    next;
    sec_data_gnt = 0; pri_req = 3'b111; pri_wstrb[0] = 4'hF; pri_wstrb[1] = 4'hF;
    sample; chk("mr_restart_gnt", 64'(pri_gnt), 64'b001);
    next;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
